// File: rtl/piezo_pkg.sv
// piezo_pkg: note format, sequencer states, note constants and tune ROM.
// Shared by piezo_seq and its tone generator.
package piezo_pkg;

  typedef struct packed {
    logic [15:0] period;
    logic [2:0]  units;
  } note_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] NOTE_G6 = 16'd31888;
  localparam logic [15:0] NOTE_C7 = 16'd23890;
  localparam logic [15:0] NOTE_E7 = 16'd18961;
  localparam logic [15:0] NOTE_G7 = 16'd15944;

  localparam int ROM_TUNES = 3;
  localparam int ROM_NOTES = 8;
  localparam int RTW = $clog2(ROM_TUNES);
  localparam int RNW = $clog2(ROM_NOTES);

  localparam note_t REST = '{16'd0, 3'd0};

  // units==0 terminates a tune
  localparam note_t TUNE_ROM [ROM_TUNES][ROM_NOTES] = '{
    '{'{NOTE_G6, 3'd2}, '{NOTE_C7, 3'd2},
      '{NOTE_E7, 3'd2}, REST, REST, REST,
      REST, REST},
    '{'{NOTE_G7, 3'd2}, '{NOTE_E7, 3'd1},
      '{NOTE_G7, 3'd2}, '{NOTE_E7, 3'd1},
      '{NOTE_C7, 3'd2}, '{NOTE_G6, 3'd4},
      REST, REST},
    '{'{NOTE_G6, 3'd2}, '{NOTE_C7, 3'd2},
      '{NOTE_E7, 3'd2}, '{NOTE_G7, 3'd3},
      '{NOTE_E7, 3'd1}, '{NOTE_G7, 3'd4},
      REST, REST}
  };

endpackage

// File: rtl/piezo_seq_tone_gen.sv
// piezo_tone_gen: 50% duty square wave; phase restarts on load.
// Ports: clk, rst_n, load (note start), period [15:0], piezo (tone out).
module piezo_tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] period,
  output logic        piezo
);

  logic [15:0] per_q;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      per_q <= period;
      cnt   <= period - 16'd1;
    end else if (cnt == '0) begin
      cnt   <= per_q - 16'd1;
    end else begin
      cnt   <= cnt - 16'd1;
    end
  end

  assign piezo = (cnt >= (per_q >> 1));

endmodule

// File: rtl/piezo_seq.sv
// piezo_seq: multi-tune piezo sequencer, tune 0 preempts, others on holdoff.
// Ports: clk, rst_n, req[NUM_TUNES], piezo, piezo_n, busy, tune_id.
module piezo_seq
  import piezo_pkg::*;
#(
  parameter int FAST_SIM  = 1,
  parameter int CLK_HZ    = 50_000_000,
  parameter int NUM_TUNES = 3,
  parameter int MAX_NOTES = 8,
  parameter int DUR_SHIFT = 22,
  localparam int TW = (NUM_TUNES > 1) ?
    $clog2(NUM_TUNES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_TUNES-1:0] req,
  output logic                 piezo,
  output logic                 piezo_n,
  output logic                 busy,
  output logic [TW-1:0]        tune_id
);

  localparam int NW = (MAX_NOTES > 1) ?
    $clog2(MAX_NOTES) : 1;
  localparam int DW = DUR_SHIFT + 3;
  // fast unit is capped by the counter's own unit
  localparam int USH = (FAST_SIM != 0) ?
    ((DUR_SHIFT < 13) ? DUR_SHIFT : 13) :
    DUR_SHIFT;
  localparam longint REP_L = (FAST_SIM != 0) ?
    64'd5000 : 3 * longint'(CLK_HZ);
  localparam int HW = $clog2(REP_L + 1);
  localparam logic [HW-1:0] REPEAT = HW'(REP_L);

  state_t        state, state_nx;
  logic [TW-1:0] tune_q, tune_nx;
  logic [NW-1:0] idx_q, idx_nx;
  logic [DW-1:0] dur_q;
  logic [HW-1:0] hold_q;
  logic          load;
  logic          hold_ld;
  logic          pend;
  logic [TW-1:0] pick;
  logic          last;
  note_t         nxt;
  note_t         note_ld;
  logic          tone;

  function automatic note_t tune_note(
    input logic [TW-1:0] t,
    input logic [NW-1:0] n
  );
    note_t r;
    r = '0;
    if (int'(t) < ROM_TUNES &&
        int'(n) < ROM_NOTES)
      r = TUNE_ROM[RTW'(t)][RNW'(n)];
    return r;
  endfunction

  function automatic logic [15:0] scale(
    input logic [15:0] p
  );
    logic [15:0] s;
    s = p;
    if (FAST_SIM != 0) begin
      s = p >> 9;
      if (s < 16'd2) s = 16'd2;
    end
    return s;
  endfunction

  always_comb begin
    pend = 1'b0;
    pick = '0;
    // descending scan so the lowest index wins
    for (int k = NUM_TUNES - 1; k >= 1; k--) begin
      if (req[k]) begin
        pend = 1'b1;
        pick = TW'(k);
      end
    end
  end

  always_comb begin
    nxt  = tune_note(tune_q, idx_q + NW'(1));
    last = (idx_q == NW'(MAX_NOTES - 1)) ||
           (nxt.units == 3'd0);
  end

  always_comb begin
    state_nx = state;
    tune_nx  = tune_q;
    idx_nx   = idx_q;
    load     = 1'b0;
    hold_ld  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req[0]) begin
          tune_nx  = '0;
          idx_nx   = '0;
          load     = 1'b1;
          state_nx = PLAY;
        end else if (pend && hold_q == '0) begin
          tune_nx  = pick;
          idx_nx   = '0;
          load     = 1'b1;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (req[0] && tune_q != '0) begin
          tune_nx = '0;
          idx_nx  = '0;
          load    = 1'b1;
        end else if (dur_q == '0) begin
          if (last) begin
            state_nx = DONE;
          end else begin
            idx_nx = idx_q + NW'(1);
            load   = 1'b1;
          end
        end
      end
      DONE: begin
        idx_nx = '0;
        if (tune_q == '0 && req[0]) begin
          load     = 1'b1;
          state_nx = PLAY;
        end else begin
          hold_ld  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    note_ld = tune_note(tune_nx, idx_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tune_q <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nx;
      tune_q <= tune_nx;
      idx_q  <= idx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dur_q <= '0;
    else if (load)
      dur_q <= (DW'(note_ld.units) << USH) - DW'(1);
    else if (busy && dur_q != '0)
      dur_q <= dur_q - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_q <= '0;
    else if (hold_ld)
      hold_q <= REPEAT;
    else if (!busy && hold_q != '0)
      hold_q <= hold_q - HW'(1);
  end

  piezo_tone_gen u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .period (scale(note_ld.period)),
    .piezo  (tone)
  );

  assign busy    = (state == PLAY);
  assign tune_id = tune_q;
  assign piezo   = busy & tone;
  assign piezo_n = busy & ~tone;

endmodule

// File: tb/tb_piezo_seq.sv
// tb_piezo_seq: directed checks of piezo_seq, FAST_SIM with 256-clk unit.
// Unit 256 clk; periods >>9: G6=62, C7=46, G7=31; holdoff 5000.
module tb_piezo_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       piezo;
  logic       piezo_n;
  logic       busy;
  logic [1:0] tune_id;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n, c0, cd, cp;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  piezo_seq #(
    .FAST_SIM  (1),
    .CLK_HZ    (50_000_000),
    .NUM_TUNES (3),
    .MAX_NOTES (8),
    .DUR_SHIFT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .piezo   (piezo),
    .piezo_n (piezo_n),
    .busy    (busy),
    .tune_id (tune_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, got, exp);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic run_len(
    input  logic lvl,
    output int   len
  );
    len = 0;
    while (piezo === lvl && len < 200) begin
      len++;
      tick();
    end
  endtask

  task automatic wait_busy(
    input logic lvl,
    input int   lim
  );
    int s;
    s = cyc;
    while (busy !== lvl && cyc - s < lim) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_piezo", piezo, 0);
    chk("rst_piezo_n", piezo_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tune_id", tune_id, 0);
    rst_n = 1'b1;
    tick();

    n = 0;
    repeat (10000) begin
      if ((piezo | piezo_n | busy) !== 1'b0) n++;
      tick();
    end
    chk("idle_quiet", n, 0);

    // tune 2, one-clock request pulse
    req = 3'b100;
    tick();
    req = 3'b000;
    c0 = cyc;
    chk("t2_busy", busy, 1);
    chk("t2_id", tune_id, 2);
    chk("t2_piezo", piezo, 1);
    chk("t2_piezo_n", piezo_n, 0);
    run_len(1'b1, n);
    chk("t2_g6_high", n, 31);
    run_len(1'b0, n);
    chk("t2_g6_low", n, 31);
    to_cyc(c0 + 534);
    chk("t2_c7_last_high", piezo, 1);
    tick();
    chk("t2_c7_first_low", piezo, 0);
    wait_busy(1'b0, 4000);
    chk("t2_len", cyc - c0, 3584);
    chk("t2_done_piezo", piezo, 0);
    chk("t2_done_piezo_n", piezo_n, 0);
    n = 0;
    repeat (5200) begin
      if (busy !== 1'b0) n++;
      tick();
    end
    chk("t2_no_replay", n, 0);

    // tune 1 beats tune 2, tune 2 after holdoff
    req = 3'b110;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_id", tune_id, 1);
    req = 3'b100;
    c0 = cyc;
    run_len(1'b1, n);
    chk("t1_g7_high", n, 16);
    wait_busy(1'b0, 4000);
    chk("t1_len", cyc - c0, 3072);
    cd = cyc;
    wait_busy(1'b1, 6000);
    chk("t2_holdoff", cyc - cd, 5002);
    chk("t2_after_t1_id", tune_id, 2);
    c0 = cyc;

    // tune 0 preempts tune 2 in note 3
    to_cyc(c0 + 1600);
    req = 3'b001;
    tick();
    cp = cyc;
    chk("pre_id", tune_id, 0);
    chk("pre_busy", busy, 1);
    run_len(1'b1, n);
    chk("pre_g6_high", n, 31);
    to_cyc(cp + 1536);
    chk("t0_gap", busy, 0);
    tick();
    chk("t0_loop_busy", busy, 1);
    chk("t0_loop_id", tune_id, 0);
    to_cyc(cp + 2000);
    req = 3'b000;
    wait_busy(1'b0, 2000);
    chk("t0_pass_end", cyc - cp, 3073);
    cd = cyc;
    n = 0;
    repeat (50) begin
      if (busy !== 1'b0) n++;
      tick();
    end
    chk("t0_stopped", n, 0);

    // async reset mid-note
    req = 3'b100;
    wait_busy(1'b1, 6000);
    chk("t0_holdoff", cyc - cd, 5002);
    repeat (10) tick();
    chk("pre_rst_piezo", piezo, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_piezo", piezo, 0);
    chk("arst_piezo_n", piezo_n, 0);
    chk("arst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rel_busy", busy, 0);
    tick();
    chk("rel_restart", busy, 1);
    chk("rel_id", tune_id, 2);
    run_len(1'b1, n);
    chk("rel_note0_high", n, 31);
    req = 3'b000;
    wait_busy(1'b0, 4000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
